// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the ALU issue controller: opcode values, one-hot
// ALU enable codes, FSM state encoding and the field layout of i_INST.
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

  localparam int INST_W = 11;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 8;

  // i_INST field positions
  localparam int OP_HI = 10;
  localparam int OP_LO = 9;
  localparam int RD_HI = 8;
  localparam int RD_LO = 6;
  localparam int RX_HI = 5;
  localparam int RX_LO = 3;
  localparam int RY_HI = 2;
  localparam int RY_LO = 0;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_CMP = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  localparam logic [2:0] EN_NONE = 3'b000;
  localparam logic [2:0] EN_CMP  = 3'b001;
  localparam logic [2:0] EN_ADD  = 3'b010;
  localparam logic [2:0] EN_SUB  = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_RDY  = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_RELEASE   = 3'd4
  } state_e;

  function automatic logic [2:0] op_to_en(input op_e op);
    case (op)
      OP_CMP:  return EN_CMP;
      OP_ADD:  return EN_ADD;
      OP_SUB:  return EN_SUB;
      default: return EN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------------------
// alu_regfile
// 8 x 16 register file: two asynchronous read ports, one synchronous write
// port, all entries cleared by asynchronous active-low reset.
// Ports:
//   i_clk, i_rst_n          clock / async active-low reset
//   i_ra_x, o_rd_x          read port X (address / data)
//   i_ra_y, o_rd_y          read port Y (address / data)
//   i_we, i_wa, i_wd        write enable / address / data
// ---------------------------------------------------------------------------
module alu_regfile
  import alu_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_ra_x,
  output logic [DATA_W-1:0] o_rd_x,
  input  logic [ADDR_W-1:0] i_ra_y,
  output logic [DATA_W-1:0] o_rd_y,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wa,
  input  logic [DATA_W-1:0] i_wd
);

  logic [DATA_W-1:0] r_mem [NREGS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_rd_x = r_mem[i_ra_x];
  assign o_rd_y = r_mem[i_ra_y];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Accepts one instruction at a time, latches its operands from the local
// register file, requests the external ALU with a one-hot enable, waits for
// the ALU completion pulse and writes the result back to rd.
//
// Optional feature macro: ALU_TIMEOUT_EN
//   defined   -> WAIT_RDY aborts after TIMEOUT_CYCLES cycles, sets sticky o_ERR
//   undefined -> WAIT_RDY waits indefinitely, o_ERR tied 0
//
// Ports:
//   i_SCLK, i_RESETB                     clock / async active-low reset
//   i_INST_VALID, o_INST_READY, i_INST   instruction handshake and word
//   i_WR_EN, i_WR_ADDR, i_WR_DATA        external register load port
//   o_WR_READY                           external write accepted this cycle
//   o_RX, o_RY                           operands to ALU
//   o_ALU_ENABLE                         one-hot request 001 cmp/010 add/100 sub
//   i_ALU_READY, i_RESULT                ALU completion pulse and result
//   o_DONE, o_DONE_DATA                  retire pulse and value written to rd
//   o_ERR                                sticky timeout flag
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | ready for an instruction, ALU enable low
// ST_ISSUE     | first (single) cycle of ALU request
// ST_WAIT_RDY  | ALU request held until i_ALU_READY (or timeout)
// ST_WRITEBACK | result written to rd, o_DONE pulse, external writes blocked
// ST_RELEASE   | guard cycle keeping enable low before the next request
// ---------------------------------------------------------------------------
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              i_SCLK,
  input  logic              i_RESETB,
  input  logic              i_INST_VALID,
  output logic              o_INST_READY,
  input  logic [INST_W-1:0] i_INST,
  input  logic              i_WR_EN,
  input  logic [ADDR_W-1:0] i_WR_ADDR,
  input  logic [DATA_W-1:0] i_WR_DATA,
  output logic              o_WR_READY,
  output logic [DATA_W-1:0] o_RX,
  output logic [DATA_W-1:0] o_RY,
  output logic [2:0]        o_ALU_ENABLE,
  input  logic              i_ALU_READY,
  input  logic [DATA_W-1:0] i_RESULT,
  output logic              o_DONE,
  output logic [DATA_W-1:0] o_DONE_DATA,
  output logic              o_ERR
);

  state_e            r_state;
  state_e            w_next_state;
  op_e               r_op;
  logic [ADDR_W-1:0] r_rd;
  logic              r_inst_ready;
  logic              r_wr_ready;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_ry;
  logic [2:0]        r_alu_en;
  logic              r_done;
  logic [DATA_W-1:0] r_done_data;

  logic              w_accept;
  op_e               w_op_in;
  logic [DATA_W-1:0] w_rf_rx;
  logic [DATA_W-1:0] w_rf_ry;
  logic              w_wb_we;
  logic              w_rf_we;
  logic [ADDR_W-1:0] w_rf_wa;
  logic [DATA_W-1:0] w_rf_wd;
  logic              w_tmo_hit;

  logic              w_inst_ready_nxt;
  logic              w_wr_ready_nxt;
  logic [2:0]        w_alu_en_nxt;
  logic              w_done_nxt;
  logic [DATA_W-1:0] w_done_data_nxt;

  // r_inst_ready is high exactly in IDLE, so it doubles as the IDLE qualifier
  assign w_accept = r_inst_ready & i_INST_VALID;
  assign w_op_in  = op_e'(i_INST[OP_HI:OP_LO]);

  // Writeback owns the write port in WRITEBACK; external writes are blocked
  // there by o_WR_READY, so the two sources never collide.
  assign w_wb_we = (r_state == ST_WRITEBACK) && (r_op != OP_NOP);
  assign w_rf_we = w_wb_we | (i_WR_EN & r_wr_ready);
  assign w_rf_wa = w_wb_we ? r_rd : i_WR_ADDR;
  assign w_rf_wd = w_wb_we ? r_done_data : i_WR_DATA;

  alu_regfile u_regfile (
    .i_clk   (i_SCLK),
    .i_rst_n (i_RESETB),
    .i_ra_x  (i_INST[RX_HI:RX_LO]),
    .o_rd_x  (w_rf_rx),
    .i_ra_y  (i_INST[RY_HI:RY_LO]),
    .o_rd_y  (w_rf_ry),
    .i_we    (w_rf_we),
    .i_wa    (w_rf_wa),
    .i_wd    (w_rf_wd)
  );

`ifdef ALU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_err;

  // Abort on the WAIT_RDY cycle that brings the count to TIMEOUT_CYCLES;
  // a ready pulse in that same cycle still wins.
  assign w_tmo_hit = (r_state == ST_WAIT_RDY) && !i_ALU_READY &&
                     (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_SCLK or negedge i_RESETB) begin
    if (!i_RESETB) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == ST_WAIT_RDY) r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
      else                        r_tmo_cnt <= '0;
      if (w_tmo_hit) r_err <= 1'b1;
    end
  end

  assign o_ERR = r_err;
`else
  assign w_tmo_hit = 1'b0;
  assign o_ERR     = 1'b0;
`endif

  // State register
  always_ff @(posedge i_SCLK or negedge i_RESETB) begin
    if (!i_RESETB) r_state <= ST_IDLE;
    else           r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = (w_op_in == OP_NOP) ? ST_WRITEBACK : ST_ISSUE;
      end
      ST_ISSUE:     w_next_state = ST_WAIT_RDY;
      ST_WAIT_RDY: begin
        if (i_ALU_READY)    w_next_state = ST_WRITEBACK;
        else if (w_tmo_hit) w_next_state = ST_RELEASE;
      end
      ST_WRITEBACK: w_next_state = ST_RELEASE;
      ST_RELEASE:   w_next_state = ST_IDLE;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, decoded from the
  // state being entered so every output is a flop.
  always_comb begin
    w_inst_ready_nxt = (w_next_state == ST_IDLE);
    w_wr_ready_nxt   = (w_next_state != ST_WRITEBACK);
    w_done_nxt       = (w_next_state == ST_WRITEBACK);
    w_alu_en_nxt     = EN_NONE;
    if ((w_next_state == ST_ISSUE) || (w_next_state == ST_WAIT_RDY)) begin
      w_alu_en_nxt = (r_state == ST_IDLE) ? op_to_en(w_op_in) : op_to_en(r_op);
    end
    w_done_data_nxt = r_done_data;
    if ((r_state == ST_WAIT_RDY) && i_ALU_READY) begin
      w_done_data_nxt = i_RESULT;
    end else if (w_accept && (w_op_in == OP_NOP)) begin
      w_done_data_nxt = '0;
    end
  end

  always_ff @(posedge i_SCLK or negedge i_RESETB) begin
    if (!i_RESETB) begin
      r_inst_ready <= 1'b1;
      r_wr_ready   <= 1'b1;
      r_alu_en     <= EN_NONE;
      r_done       <= 1'b0;
      r_done_data  <= '0;
      r_rx         <= '0;
      r_ry         <= '0;
      r_op         <= OP_NOP;
      r_rd         <= '0;
    end else begin
      r_inst_ready <= w_inst_ready_nxt;
      r_wr_ready   <= w_wr_ready_nxt;
      r_alu_en     <= w_alu_en_nxt;
      r_done       <= w_done_nxt;
      r_done_data  <= w_done_data_nxt;
      if (w_accept) begin
        r_rx <= w_rf_rx;
        r_ry <= w_rf_ry;
        r_op <= w_op_in;
        r_rd <= i_INST[RD_HI:RD_LO];
      end
    end
  end

  assign o_INST_READY = r_inst_ready;
  assign o_WR_READY   = r_wr_ready;
  assign o_RX         = r_rx;
  assign o_RY         = r_ry;
  assign o_ALU_ENABLE = r_alu_en;
  assign o_DONE       = r_done;
  assign o_DONE_DATA  = r_done_data;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Self-checking bench for alu_issue_ctrl. The bench plays the ALU and keeps
// its own model of the eight registers; expected operands, results and
// handshake timing come from that model and the instruction's phase.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        i_RESETB;
  logic        i_INST_VALID;
  logic        o_INST_READY;
  logic [10:0] i_INST;
  logic        i_WR_EN;
  logic [2:0]  i_WR_ADDR;
  logic [15:0] i_WR_DATA;
  logic        o_WR_READY;
  logic [15:0] o_RX, o_RY;
  logic [2:0]  o_ALU_ENABLE;
  logic        i_ALU_READY;
  logic [15:0] i_RESULT;
  logic        o_DONE;
  logic [15:0] o_DONE_DATA;
  logic        o_ERR;

  int checks   = 0;
  int failures = 0;
  logic [15:0] model [8];

  always #5 clk = ~clk;

  alu_issue_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .i_SCLK       (clk),
    .i_RESETB     (i_RESETB),
    .i_INST_VALID (i_INST_VALID),
    .o_INST_READY (o_INST_READY),
    .i_INST       (i_INST),
    .i_WR_EN      (i_WR_EN),
    .i_WR_ADDR    (i_WR_ADDR),
    .i_WR_DATA    (i_WR_DATA),
    .o_WR_READY   (o_WR_READY),
    .o_RX         (o_RX),
    .o_RY         (o_RY),
    .o_ALU_ENABLE (o_ALU_ENABLE),
    .i_ALU_READY  (i_ALU_READY),
    .i_RESULT     (i_RESULT),
    .o_DONE       (o_DONE),
    .o_DONE_DATA  (o_DONE_DATA),
    .o_ERR        (o_ERR)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // The ALU's behaviour as seen by this bench: compare returns 1 on equality
  function automatic logic [15:0] alu_ref(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    case (op)
      2'b01:   return (a == b) ? 16'd1 : 16'd0;
      2'b10:   return a + b;
      2'b11:   return a - b;
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [2:0] en_ref(input logic [1:0] op);
    case (op)
      2'b01:   return 3'b001;
      2'b10:   return 3'b010;
      2'b11:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // External write issued from IDLE; always accepted there
  task automatic ext_wr(input logic [2:0] a, input logic [15:0] d);
    chk("wr_ready_idle", 16'(o_WR_READY), 16'd1);
    i_WR_EN = 1'b1; i_WR_ADDR = a; i_WR_DATA = d;
    @(negedge clk);
    i_WR_EN = 1'b0;
    model[a] = d;
  endtask

  // One full instruction starting and ending at a negedge in IDLE
  task automatic do_inst(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rx,
                         input logic [2:0] ry, input int lat, input bit spur,
                         input bit ew_fly, input bit ew_wb,
                         input logic [2:0] ew_a, input logic [15:0] ew_d);
    logic [15:0] a, b, res;
    logic [2:0]  en_exp;
    a = model[rx]; b = model[ry];
    res = alu_ref(op, a, b);
    en_exp = en_ref(op);
    chk("inst_ready_idle", 16'(o_INST_READY), 16'd1);
    i_INST_VALID = 1'b1; i_INST = {op, rd, rx, ry};
    @(negedge clk);
    i_INST_VALID = 1'b0; i_INST = 11'($urandom);
    chk("rx_latched", o_RX, a);
    chk("ry_latched", o_RY, b);
    chk("inst_ready_busy", 16'(o_INST_READY), 16'd0);
    if (op != 2'b00) begin
      chk("en_issue", 16'(o_ALU_ENABLE), 16'(en_exp));
      if (spur) begin i_ALU_READY = 1'b1; i_RESULT = ~res; end
      if (ew_fly) begin
        chk("wr_ready_fly", 16'(o_WR_READY), 16'd1);
        i_WR_EN = 1'b1; i_WR_ADDR = ew_a; i_WR_DATA = ew_d;
        model[ew_a] = ew_d;
      end
      @(negedge clk);
      i_ALU_READY = 1'b0; i_WR_EN = 1'b0;
      for (int k = 1; k <= lat; k++) begin
        chk("en_wait", 16'(o_ALU_ENABLE), 16'(en_exp));
        chk("done_wait", 16'(o_DONE), 16'd0);
        chk("rx_hold", o_RX, a);
        if (k == lat) begin i_ALU_READY = 1'b1; i_RESULT = res; end
        @(negedge clk);
        i_ALU_READY = 1'b0; i_RESULT = 16'($urandom);
      end
    end
    // WRITEBACK
    chk("done_wb", 16'(o_DONE), 16'd1);
    chk("done_data", o_DONE_DATA, res);
    chk("en_wb", 16'(o_ALU_ENABLE), 16'd0);
    chk("wr_ready_wb", 16'(o_WR_READY), 16'd0);
    if (ew_wb) begin i_WR_EN = 1'b1; i_WR_ADDR = ew_a; i_WR_DATA = ew_d; end
    @(negedge clk);
    i_WR_EN = 1'b0;
    if (op != 2'b00) model[rd] = res;
    // RELEASE
    chk("done_rel", 16'(o_DONE), 16'd0);
    chk("en_rel", 16'(o_ALU_ENABLE), 16'd0);
    chk("wr_ready_rel", 16'(o_WR_READY), 16'd1);
    chk("inst_ready_rel", 16'(o_INST_READY), 16'd0);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [15:0] exp_b2b;
    int acc, dones, burst, first_c, second_c, first_end, zgap;

    i_RESETB = 1'b0; i_INST_VALID = 1'b0; i_INST = '0;
    i_WR_EN = 1'b0; i_WR_ADDR = '0; i_WR_DATA = '0;
    i_ALU_READY = 1'b0; i_RESULT = '0;
    for (int i = 0; i < 8; i++) model[i] = 16'd0;
    repeat (3) @(negedge clk);
    i_RESETB = 1'b1;
    #1;
    chk("rst_inst_ready", 16'(o_INST_READY), 16'd1);
    chk("rst_wr_ready", 16'(o_WR_READY), 16'd1);
    chk("rst_en", 16'(o_ALU_ENABLE), 16'd0);
    chk("rst_done", 16'(o_DONE), 16'd0);
    chk("rst_done_data", o_DONE_DATA, 16'd0);
    chk("rst_rx", o_RX, 16'd0);
    chk("rst_ry", o_RY, 16'd0);
    chk("rst_err", 16'(o_ERR), 16'd0);
    @(negedge clk);

    // ADD r4 = r1 + r2 = 5 + 3
    ext_wr(3'd1, 16'd5);
    ext_wr(3'd2, 16'd3);
    do_inst(2'b10, 3'd4, 3'd1, 3'd2, 2, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    chk("add_data", o_DONE_DATA, 16'd8);
    do_inst(2'b00, 3'd0, 3'd4, 3'd0, 1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    chk("r4_is_8", o_RX, 16'd8);

    // SUB r0 = 3 - 5 wraps
    ext_wr(3'd1, 16'd3);
    ext_wr(3'd2, 16'd5);
    do_inst(2'b11, 3'd0, 3'd1, 3'd2, 1, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
    chk("sub_data", o_DONE_DATA, 16'hFFFE);

    // CMP r7 against r5 (both 0), then r7 = 9
    do_inst(2'b01, 3'd6, 3'd7, 3'd5, 1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    chk("cmp_eq", o_DONE_DATA, 16'd1);
    ext_wr(3'd7, 16'd9);
    do_inst(2'b01, 3'd6, 3'd7, 3'd5, 3, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    chk("cmp_ne", o_DONE_DATA, 16'd0);

    // Write in WRITEBACK dropped; in-flight writes to rx/rd
    do_inst(2'b10, 3'd5, 3'd1, 3'd2, 1, 1'b0, 1'b0, 1'b1, 3'd3, 16'h1234);
    do_inst(2'b00, 3'd0, 3'd3, 3'd5, 1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    chk("wb_write_dropped", o_RX, 16'd0);
    chk("nop_data", o_DONE_DATA, 16'd0);
    do_inst(2'b10, 3'd2, 3'd1, 3'd2, 2, 1'b0, 1'b1, 1'b0, 3'd1, 16'h4000);
    do_inst(2'b10, 3'd3, 3'd3, 3'd3, 2, 1'b0, 1'b1, 1'b0, 3'd3, 16'h0111);
    do_inst(2'b00, 3'd0, 3'd1, 3'd3, 1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    chk("fly_rx_write", o_RX, 16'h4000);

    // Back-to-back ADDs with i_INST_VALID held
    exp_b2b = model[1] + model[2];
    acc = 0; dones = 0; burst = 0; first_c = -1; second_c = -1; first_end = -1;
    i_INST = {2'b10, 3'd3, 3'd1, 3'd2};
    i_INST_VALID = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (acc == 2) i_INST_VALID = 1'b0;
      if (o_INST_READY && i_INST_VALID) acc++;
      if (o_ALU_ENABLE != 3'b000) begin
        if (burst == 0) begin
          if (first_c < 0) first_c = c;
          else if (second_c < 0) second_c = c;
        end
        if (second_c < 0) first_end = c;
        burst++;
      end else begin
        burst = 0;
      end
      i_ALU_READY = (burst == 2);
      i_RESULT = exp_b2b;
      if (o_DONE) begin
        dones++;
        chk("b2b_data", o_DONE_DATA, exp_b2b);
      end
      @(negedge clk);
    end
    i_ALU_READY = 1'b0;
    model[3] = exp_b2b;
    zgap = second_c - first_end - 1;
    chk("b2b_dones", 16'(dones), 16'd2);
    chk("b2b_period", 16'(second_c - first_c), 16'd5);
    chk("b2b_zero_gap", 16'(zgap >= 2), 16'd1);

    // Randomised instruction stream
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) ext_wr(3'($urandom), 16'($urandom));
      do_inst(2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 3'($urandom),
              int'($urandom_range(1, 4)), 1'($urandom), 1'($urandom), 1'($urandom),
              3'($urandom), 16'($urandom));
    end
    do_inst(2'b00, 3'd0, 3'd0, 3'd1, 1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    do_inst(2'b00, 3'd0, 3'd6, 3'd7, 1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);

`ifdef ALU_TIMEOUT_EN
    // ALU never answers: abort after 4 WAIT_RDY cycles
    i_INST = {2'b11, 3'd6, 3'd1, 3'd2}; i_INST_VALID = 1'b1;
    @(negedge clk);
    i_INST_VALID = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("tmo_en", 16'(o_ALU_ENABLE), 16'h0004);
      chk("tmo_done", 16'(o_DONE), 16'd0);
      chk("tmo_err_early", 16'(o_ERR), 16'd0);
      @(negedge clk);
    end
    chk("tmo_err_set", 16'(o_ERR), 16'd1);
    chk("tmo_en_rel", 16'(o_ALU_ENABLE), 16'd0);
    chk("tmo_no_done", 16'(o_DONE), 16'd0);
    @(negedge clk);
    chk("tmo_idle", 16'(o_INST_READY), 16'd1);
    chk("tmo_err_sticky", 16'(o_ERR), 16'd1);
    do_inst(2'b00, 3'd0, 3'd6, 3'd7, 1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
`endif

    // Reset in the middle of an ADD
    i_INST = {2'b10, 3'd5, 3'd1, 3'd2}; i_INST_VALID = 1'b1;
    @(negedge clk);
    i_INST_VALID = 1'b0;
    @(negedge clk);
    #2 i_RESETB = 1'b0;
    #1;
    chk("mid_rst_en", 16'(o_ALU_ENABLE), 16'd0);
    chk("mid_rst_rx", o_RX, 16'd0);
    @(negedge clk);
    i_RESETB = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = 16'd0;
    i_ALU_READY = 1'b1; i_RESULT = 16'h7777;
    #1;
    chk("mid_rst_inst_ready", 16'(o_INST_READY), 16'd1);
    chk("mid_rst_err", 16'(o_ERR), 16'd0);
    @(negedge clk);
    i_ALU_READY = 1'b0;
    chk("mid_rst_no_done", 16'(o_DONE), 16'd0);
    chk("mid_rst_en_idle", 16'(o_ALU_ENABLE), 16'd0);
    do_inst(2'b00, 3'd0, 3'd1, 3'd5, 1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    chk("mid_rst_r5_clear", o_RY, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
